// File: rtl/pwm_cond_pkg.sv
// rtl/pwm_cond_pkg.sv - shared constants, types and helpers for the PWM input conditioner
//
// Purpose: default widths/debounce length, the per-bit debounce phase type and
//          the counter-width helper used by pwm_debounce_bit.
// Ports:   none (package).
package pwm_cond_pkg;

   localparam int PWM_COND_WIDTH   = 8;
   localparam int PWM_COND_DEB_1MS = 50000;

   // Classification of one bit's debounce step on the current clock edge.
   typedef enum logic [1:0] {
      DEB_IDLE     = 2'd0,
      DEB_COUNTING = 2'd1,
      DEB_ACCEPT   = 2'd2
   } deb_phase_t;

   // ceil(log2(cycles)) with a floor of 1, so the counter can hold cycles-1.
   function automatic int cnt_width(input int cycles);
      int w;
      w = 1;
      while ((1 << w) < cycles) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/pwm_input_conditioner_if.sv
// rtl/pwm_input_conditioner_if.sv - signal bundle between board pins and the PIO-facing conditioner
//
// Purpose: groups the raw input vector, the debounced output vector, the change
//          pulse and (with PWM_COND_EDGE_CAPTURE_EN) the sticky edge flags.
// Ports:   raw_in[WIDTH], data_out[WIDTH], change_pulse,
//          edge_flags[WIDTH] / edge_clear[WIDTH] only with PWM_COND_EDGE_CAPTURE_EN.
// Modports: master = pin/PIO side, slave = conditioner.
interface pwm_input_conditioner_if #(
   parameter int WIDTH = 8
);

   logic [WIDTH-1:0] raw_in;
   logic [WIDTH-1:0] data_out;
   logic             change_pulse;
`ifdef PWM_COND_EDGE_CAPTURE_EN
   logic [WIDTH-1:0] edge_flags;
   logic [WIDTH-1:0] edge_clear;

   modport master (output raw_in, output edge_clear,
                   input data_out, input change_pulse, input edge_flags);
   modport slave  (input raw_in, input edge_clear,
                   output data_out, output change_pulse, output edge_flags);
`else
   modport master (output raw_in, input data_out, input change_pulse);
   modport slave  (input raw_in, output data_out, output change_pulse);
`endif

endinterface

// File: rtl/pwm_debounce_bit.sv
// rtl/pwm_debounce_bit.sv - one bit: 2-flop synchroniser, hold counter and stable flop
//
// Purpose: accepts a new level only after the synchronised input has differed
//          from the stable value for DEBOUNCE_CYCLES consecutive edges.
// Ports:   clk, reset_n (async assert, already synchronously released),
//          raw (asynchronous pin), stable (debounced level),
//          accept (combinational: stable takes a new value on this edge).
module pwm_debounce_bit
   import pwm_cond_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = PWM_COND_DEB_1MS,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic stable,
   output logic accept
);

   localparam int             CNT_W   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1;
   logic             s2;
   logic             stable_q;
   logic [CNT_W-1:0] cnt;
   deb_phase_t       phase;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= RESET_VAL;
         s2 <= RESET_VAL;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // Any edge where s2 matches stable drops the count, which is what rejects glitches.
   always_comb begin
      phase = DEB_IDLE;
      if (s2 != stable_q) begin
         phase = (cnt == CNT_MAX) ? DEB_ACCEPT : DEB_COUNTING;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt      <= '0;
         stable_q <= RESET_VAL;
      end else begin
         case (phase)
            DEB_COUNTING: cnt <= cnt + 1'b1;
            DEB_ACCEPT: begin
               stable_q <= s2;
               cnt      <= '0;
            end
            default:      cnt <= '0;
         endcase
      end
   end

   assign stable = stable_q;
   assign accept = (phase == DEB_ACCEPT);

endmodule

// File: rtl/pwm_input_conditioner.sv
// rtl/pwm_input_conditioner.sv - debounced, synchronised switch/button vector for the PIO in_port
//
// Purpose: WIDTH copies of pwm_debounce_bit, a registered any-bit change pulse and,
//          when PWM_COND_EDGE_CAPTURE_EN is defined, sticky rising-edge flags.
// Ports:   clk, reset_n (async active-low),
//          bus (pwm_input_conditioner_if.slave): raw_in in, data_out out,
//          change_pulse out, edge_flags out / edge_clear in (edge capture build only).
// Macro:   PWM_COND_EDGE_CAPTURE_EN enables the edge-flag register.
module pwm_input_conditioner
   import pwm_cond_pkg::*;
#(
   parameter int               WIDTH           = PWM_COND_WIDTH,
   parameter int               DEBOUNCE_CYCLES = PWM_COND_DEB_1MS,
   parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
   input logic                    clk,
   input logic                    reset_n,
   pwm_input_conditioner_if.slave bus
);

   logic             rst_meta;
   logic             rst_sync;
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] accept;
   logic             change_q;

   // Reset asserts asynchronously everywhere but releases on a clock edge,
   // so no flop sees reset removal near its sampling point.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_meta <= 1'b0;
         rst_sync <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_sync <= rst_meta;
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      pwm_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL       (RESET_VAL[g])
      ) u_bit (
         .clk     (clk),
         .reset_n (rst_sync),
         .raw     (bus.raw_in[g]),
         .stable  (stable[g]),
         .accept  (accept[g])
      );
   end

   // Registered on the same edge that stable changes, so it lines up with data_out.
   always_ff @(posedge clk or negedge rst_sync) begin
      if (!rst_sync) begin
         change_q <= 1'b0;
      end else begin
         change_q <= |accept;
      end
   end

   assign bus.data_out     = stable;
   assign bus.change_pulse = change_q;

`ifdef PWM_COND_EDGE_CAPTURE_EN
   logic [WIDTH-1:0] flags_q;

   // A bit accepting while stable is 0 is a 0->1 transition; set beats clear.
   always_ff @(posedge clk or negedge rst_sync) begin
      if (!rst_sync) begin
         flags_q <= '0;
      end else begin
         flags_q <= (flags_q & ~bus.edge_clear) | (accept & ~stable);
      end
   end

   assign bus.edge_flags = flags_q;
`endif

endmodule

// File: tb/tb_pwm_input_conditioner.sv
// tb/tb_pwm_input_conditioner.sv - self-checking bench for pwm_input_conditioner
module tb_pwm_input_conditioner;

   localparam int         W  = 8;
   localparam int         D  = 4;
   localparam logic [7:0] RV = 8'h00;

   logic clk;
   logic reset_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   done     = 0;
   int   pulse_cnt = 0;
   int   tr5       = 0;

   pwm_input_conditioner_if #(.WIDTH(W)) bus ();

   pwm_input_conditioner #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D),
      .RESET_VAL       (RV)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a bit takes value v when the last D synchronised samples (excluding
   // the one still in flight in the first flop) all equal v and differ from the
   // current output. Internal reset releases two edges after reset_n rises.
   logic [7:0] m_hist [0:D];
   logic [7:0] m_stable;
   logic       m_pulse;
   logic [7:0] m_flags;
   int         rel;

   initial begin
      logic [7:0] acc;
      bit         same;
      m_stable = RV;
      m_pulse  = 1'b0;
      m_flags  = '0;
      rel      = 0;
      for (int j = 0; j <= D; j++) m_hist[j] = RV;
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            m_stable = RV;
            m_pulse  = 1'b0;
            m_flags  = '0;
            rel      = 0;
            for (int j = 0; j <= D; j++) m_hist[j] = RV;
         end else begin
            if (rel >= 2) begin
               acc = '0;
               for (int b = 0; b < W; b++) begin
                  same = 1'b1;
                  for (int j = 2; j <= D; j++)
                     if (m_hist[j][b] != m_hist[1][b]) same = 1'b0;
                  if (same && (m_hist[1][b] != m_stable[b])) acc[b] = 1'b1;
               end
`ifdef PWM_COND_EDGE_CAPTURE_EN
               m_flags = (m_flags & ~bus.edge_clear) | (acc & ~m_stable);
`endif
               m_pulse  = |acc;
               m_stable = (m_stable & ~acc) | (m_hist[1] & acc);
               for (int j = D; j >= 1; j--) m_hist[j] = m_hist[j-1];
               m_hist[0] = bus.raw_in;
            end else begin
               m_pulse = 1'b0;
            end
            if (rel < 2) rel++;
         end
      end
   end

   // Per-cycle comparison against the model, plus event counters for windowed checks.
   logic prev5 = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         if (done) break;
         check("data_out", 32'(bus.data_out), 32'(m_stable));
         check("change_pulse", 32'(bus.change_pulse), 32'(m_pulse));
`ifdef PWM_COND_EDGE_CAPTURE_EN
         check("edge_flags", 32'(bus.edge_flags), 32'(m_flags));
`endif
         if (bus.change_pulse === 1'b1) pulse_cnt++;
         if (bus.data_out[5] !== prev5) tr5++;
         prev5 = bus.data_out[5];
      end
   end

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset_n    = 1'b0;
      bus.raw_in = 8'hFF;
`ifdef PWM_COND_EDGE_CAPTURE_EN
      bus.edge_clear = '0;
`endif
      edges(3);
      // 1: reset hold, then release; first s1 sample two edges after release.
      check("t1_reset_data", 32'(bus.data_out), 32'h00);
      check("t1_reset_pulse", 32'(bus.change_pulse), 32'h0);
      reset_n = 1'b1;
      edges(7);
      check("t1_before_accept", 32'(bus.data_out), 32'h00);
      edges(1);
      check("t1_accept_data", 32'(bus.data_out), 32'hFF);
      check("t1_accept_pulse", 32'(bus.change_pulse), 32'h1);
      edges(1);
      check("t1_pulse_one_cycle", 32'(bus.change_pulse), 32'h0);

      bus.raw_in = 8'h00;
      edges(10);
      check("settle_zero", 32'(bus.data_out), 32'h00);

      // 2: three-cycle glitch on bit 0.
      pulse_cnt  = 0;
      bus.raw_in = 8'h01;
      edges(3);
      bus.raw_in = 8'h00;
      edges(10);
      check("t2_glitch_data", 32'(bus.data_out), 32'h00);
      check("t2_glitch_pulses", 32'(pulse_cnt), 32'd0);

      // 3: clean step to 0x08, sampled at edge N, visible at N+5.
      pulse_cnt  = 0;
      bus.raw_in = 8'h08;
      edges(5);
      check("t3_n4_data", 32'(bus.data_out), 32'h00);
      check("t3_n4_pulse", 32'(bus.change_pulse), 32'h0);
      edges(1);
      check("t3_n5_data", 32'(bus.data_out), 32'h08);
      check("t3_n5_pulse", 32'(bus.change_pulse), 32'h1);
      edges(10);
      check("t3_pulses", 32'(pulse_cnt), 32'd1);

      // 4: bit 5 toggles every 2 cycles for 12 cycles, then held high.
      pulse_cnt = 0;
      tr5       = 0;
      for (int k = 0; k < 12; k++) begin
         bus.raw_in = (((k / 2) % 2) == 0) ? 8'h28 : 8'h08;
         edges(1);
      end
      bus.raw_in = 8'h28;
      edges(12);
      check("t4_data", 32'(bus.data_out), 32'h28);
      check("t4_bit5_transitions", 32'(tr5), 32'd1);
      check("t4_pulses", 32'(pulse_cnt), 32'd1);

      // 5: reset while counters are at 2, then full requalification.
      bus.raw_in = 8'h81;
      edges(4);
      reset_n = 1'b0;
      #1;
      check("t5_reset_data", 32'(bus.data_out), 32'h00);
      check("t5_reset_pulse", 32'(bus.change_pulse), 32'h0);
      edges(2);
      reset_n = 1'b1;
      edges(7);
      check("t5_before_accept", 32'(bus.data_out), 32'h00);
      edges(1);
      check("t5_accept_data", 32'(bus.data_out), 32'h81);
      edges(2);

`ifdef PWM_COND_EDGE_CAPTURE_EN
      // 6: sticky rising-edge flags with set-wins-over-clear.
      bus.edge_clear = 8'hFF;
      edges(1);
      bus.edge_clear = 8'h00;
      check("t6_cleared", 32'(bus.edge_flags), 32'h00);
      bus.raw_in = 8'h01;
      edges(10);
      bus.raw_in = 8'h81;
      edges(6);
      check("t6_rise_flag", 32'(bus.edge_flags), 32'h80);
      edges(5);
      check("t6_sticky", 32'(bus.edge_flags), 32'h80);
      bus.raw_in = 8'h01;
      edges(10);
      bus.edge_clear = 8'h80;
      edges(1);
      bus.edge_clear = 8'h00;
      check("t6_clear_before_set", 32'(bus.edge_flags), 32'h00);
      bus.raw_in = 8'h81;
      edges(5);
      bus.edge_clear = 8'h80;
      edges(1);
      bus.edge_clear = 8'h00;
      check("t6_set_wins", 32'(bus.edge_flags), 32'h80);
      check("t6_set_wins_data", 32'(bus.data_out), 32'h81);
      bus.edge_clear = 8'h80;
      edges(1);
      bus.edge_clear = 8'h00;
      check("t6_clear_alone", 32'(bus.edge_flags), 32'h00);
      edges(2);
`endif

      done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_input_conditioner.md
Name: pwm_input_conditioner

Overview:
- Conditions raw, asynchronous board inputs (switches/buttons) before they reach the 8-bit PIO input port that the Nios reads as the PWM setpoint.
- Per bit: 2-flop synchroniser, then a counter-based debouncer.
- The registered, debounced vector drives the PIO in_port directly.
- A one-cycle change pulse is available for interrupt or edge logic.

Parameters:
- WIDTH, 8, number of input bits; must match the PIO in_port width.
- DEBOUNCE_CYCLES, 50000, clk cycles a synchronised level must hold before it is accepted (1 ms at 50 MHz); legal range is 1 to 2^20.
- RESET_VAL, 0, value of data_out and of the internal stable state while in reset.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- raw_in  input  WIDTH  asynchronous pin inputs; may bounce.
- data_out  output  WIDTH  debounced, registered value; connects to the PIO in_port.
- change_pulse  output  1  high for exactly one cycle when any data_out bit changes.
- edge_flags  output  WIDTH  sticky rising-edge flags (only with PWM_COND_EDGE_CAPTURE_EN).
- edge_clear  input  WIDTH  per-bit clear for edge_flags (only with PWM_COND_EDGE_CAPTURE_EN).

Behaviour:
- Clock and reset: clk is the clock; reset is reset_n, asynchronous, active-low. All flops use async assert and sync deassert at the top level.
- Reset values:
  - sync stages s1, s2 = RESET_VAL.
  - counters = 0.
  - stable = data_out = RESET_VAL.
  - change_pulse = 0.
  - edge_flags = 0.
- Synchroniser, per bit: s1 <= raw_in; s2 <= s1. Only s2 is used downstream.
- Counter width: CNT_W = clog2(DEBOUNCE_CYCLES), minimum 1.
- Debounce, per bit, evaluated every edge:
  - IDLE (s2 == stable): cnt <= 0.
  - COUNTING (s2 != stable and cnt < DEBOUNCE_CYCLES-1): cnt <= cnt+1.
  - ACCEPT (s2 != stable and cnt == DEBOUNCE_CYCLES-1): stable <= s2; cnt <= 0.
- Glitch rejection: any return of s2 to stable before ACCEPT resets cnt. A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no output change.
- Latency: a level first sampled into s1 at edge N appears on data_out at edge N+1+DEBOUNCE_CYCLES. data_out is the stable register itself; there is no extra stage.
- change_pulse is registered high at the same edge data_out changes. It is the OR over bits of ACCEPT, so multiple bits accepting in the same cycle give one single-cycle pulse.
- Counters never wrap: cnt is bounded by DEBOUNCE_CYCLES-1.
- Reset asserted mid-count clears all state immediately. After release, data_out re-qualifies from RESET_VAL.
- DEBOUNCE_CYCLES == 1: ACCEPT on the first mismatch cycle, so latency is 2 cycles.

Optional Feature:
- Macro: PWM_COND_EDGE_CAPTURE_EN.
- Defined:
  - edge_flags and edge_clear ports exist.
  - edge_flags[i] is set on a 0->1 ACCEPT of bit i.
  - edge_clear[i] clears it the next edge.
  - A set and a clear in the same cycle leave the flag set (set wins).
- Undefined: both ports and all flag logic are absent; remaining behaviour is identical.

Decomposition:
- Package pwm_cond_pkg holds:
  - constants PWM_COND_WIDTH = 8 and PWM_COND_DEB_1MS = 50000.
  - function cnt_width(cycles), used for CNT_W.
- Sub-module pwm_debounce_bit holds one bit's synchroniser, counter and stable flop, and outputs stable plus accept.
- The top level:
  - instantiates WIDTH copies of pwm_debounce_bit via generate;
  - ORs the accept outputs into change_pulse;
  - holds the optional edge-flag register.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=8, RESET_VAL=0 unless stated):
1. Reset hold: raw_in=0xFF with reset_n low -> data_out=0x00 and change_pulse=0. After release, data_out=0xFF exactly 5 edges after the first s1 sample, with one change_pulse.
2. Glitch: bit 0 high for 3 cycles, then low -> data_out stays 0x00 and change_pulse never asserts.
3. Clean step: raw_in 0x00->0x08 sampled at edge N -> data_out=0x08 at edge N+5, change_pulse high only in that cycle.
4. Bounce: bit 5 toggles every 2 cycles for 12 cycles, then held 1 -> exactly one 0->1 transition on data_out and one change_pulse.
5. Reset mid-count: raw_in=0x81 and cnt=2, then reset_n pulsed low -> data_out=0x00 and counters=0 immediately. After release, data_out=0x81 after a full 5-edge requalification.
6. With PWM_COND_EDGE_CAPTURE_EN:
   - bit 7 rising -> edge_flags=0x80 and sticky;
   - edge_clear=0x80 in the same cycle as a new bit-7 accept -> edge_flags stays 0x80;
   - edge_clear=0x80 alone -> edge_flags=0x00 next edge.
